// File: rtl/drop_sequencer.sv
// drop_sequencer: cursor, turn and drop control for a 7-column x 6-row panel.
// Define DROP_ANIM_EN to animate the falling piece; otherwise accepted drops write on the next cycle.

module drop_sequencer #(
    parameter int DROP_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       put,
    input  logic       game_over,
    output logic [2:0] cursor,
    output logic       player,
    output logic       busy,
    output logic       anim_valid,
    output logic [2:0] anim_row,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_data,
    output logic       move_done,
    output logic       invalid_move,
    output logic       full_panel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FALL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_TICK = 8'(DROP_TICKS - 1);
    localparam logic [2:0] MAX_COL   = 3'd6;
    localparam logic [2:0] FULL_COL  = 3'd6;
    localparam logic [2:0] TOP_ROW   = 3'd5;

    state_t     state_q, state_d;
    logic [2:0] cursor_q, cursor_d;
    logic       player_q, player_d;
    logic [2:0] height_q [7];
    logic [2:0] height_d [7];
    logic [2:0] target_q, target_d;
    logic [2:0] animRow_q, animRow_d;
    logic [7:0] tick_q, tick_d;
    logic       invalid_q, invalid_d;
    logic       fullPanel_q, fullPanel_d;

    logic [2:0] curHeight;
    logic       acceptPut;
    logic       rowDone;
    logic       animValid;

    always_comb begin
        curHeight = '0;
        for (int c = 0; c < 7; c++) begin
            if (cursor_q == 3'(c)) begin
                curHeight = height_q[c];
            end
        end
    end

    assign acceptPut = (state_q == IDLE) && put && !game_over && (curHeight < FULL_COL);
    assign rowDone   = (tick_q == LAST_TICK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acceptPut) begin
`ifdef DROP_ANIM_EN
                    state_d = FALL;
`else
                    state_d = WRITE;
`endif
                end
            end
            FALL: begin
                if (rowDone && (animRow_q == target_q)) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Cursor moves and put handling only happen in IDLE; put blocks any move in the same cycle.
    always_comb begin
        cursor_d    = cursor_q;
        player_d    = player_q;
        height_d    = height_q;
        target_d    = target_q;
        animRow_d   = animRow_q;
        tick_d      = tick_q;
        invalid_d   = invalid_q;
        case (state_q)
            IDLE: begin
                if (put) begin
                    if (!game_over) begin
                        if (curHeight < FULL_COL) begin
                            target_d  = curHeight;
                            animRow_d = TOP_ROW;
                            tick_d    = '0;
                            invalid_d = 1'b0;
                        end else begin
                            invalid_d = 1'b1;
                        end
                    end
                end else if (left && !right) begin
                    invalid_d = 1'b0;
                    if (cursor_q != 3'd0) begin
                        cursor_d = cursor_q - 3'd1;
                    end
                end else if (right && !left) begin
                    invalid_d = 1'b0;
                    if (cursor_q != MAX_COL) begin
                        cursor_d = cursor_q + 3'd1;
                    end
                end
            end
            FALL: begin
                if (rowDone) begin
                    tick_d = '0;
                    if (animRow_q != target_q) begin
                        animRow_d = animRow_q - 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            WRITE: begin
                player_d = ~player_q;
                for (int c = 0; c < 7; c++) begin
                    if (cursor_q == 3'(c)) begin
                        height_d[c] = height_q[c] + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Computed from next heights so the flag rises right after the completing write.
    always_comb begin
        fullPanel_d = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (height_d[c] != FULL_COL) begin
                fullPanel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_q    <= 3'd3;
            player_q    <= 1'b0;
            target_q    <= '0;
            animRow_q   <= '0;
            tick_q      <= '0;
            invalid_q   <= 1'b0;
            fullPanel_q <= 1'b0;
            for (int c = 0; c < 7; c++) begin
                height_q[c] <= '0;
            end
        end else begin
            cursor_q    <= cursor_d;
            player_q    <= player_d;
            target_q    <= target_d;
            animRow_q   <= animRow_d;
            tick_q      <= tick_d;
            invalid_q   <= invalid_d;
            fullPanel_q <= fullPanel_d;
            for (int c = 0; c < 7; c++) begin
                height_q[c] <= height_d[c];
            end
        end
    end

`ifdef DROP_ANIM_EN
    assign animValid = (state_q == FALL);
`else
    assign animValid = 1'b0;
`endif

    always_comb begin
        cursor       = cursor_q;
        player       = player_q;
        busy         = (state_q != IDLE);
        anim_valid   = animValid;
        anim_row     = animValid ? animRow_q : 3'd0;
        wr_en        = 1'b0;
        wr_row       = '0;
        wr_col       = '0;
        wr_data      = '0;
        move_done    = 1'b0;
        invalid_move = invalid_q;
        full_panel   = fullPanel_q;
        if (state_q == WRITE) begin
            wr_en     = 1'b1;
            move_done = 1'b1;
            wr_row    = target_q;
            wr_col    = cursor_q;
            wr_data   = player_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_drop_sequencer.sv
// Self-checking bench for drop_sequencer: directed vector table, corner sequences and
// randomized pulses compared every cycle against a turn/height model of the game rules.

module tb_drop_sequencer;

    localparam int DT = 4;
`ifdef DROP_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       put = 1'b0;
    logic       game_over = 1'b0;
    logic [2:0] cursor;
    logic       player;
    logic       busy;
    logic       anim_valid;
    logic [2:0] anim_row;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_data;
    logic       move_done;
    logic       invalid_move;
    logic       full_panel;

    always #5 clk = ~clk;

    drop_sequencer #(.DROP_TICKS(DT)) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
        .game_over(game_over), .cursor(cursor), .player(player), .busy(busy),
        .anim_valid(anim_valid), .anim_row(anim_row), .wr_en(wr_en),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .move_done(move_done), .invalid_move(invalid_move), .full_panel(full_panel)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int cycleNo = 0;

    // Game model: remain = -1 when idle, otherwise cycles left before the write cycle (0 = writing).
    int mCursor, mPlayer, mInvalid, mFull, mRemain, mTarget, mFallLen;
    int mHeight[7];

    typedef struct {
        bit l, r, p, go;
        int cur;
        bit bsy;
        bit inv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(bit l, bit r, bit p, bit go, int cur);
        vec_t v;
        v.l = l; v.r = r; v.p = p; v.go = go;
        v.cur = cur; v.bsy = 1'b0; v.inv = 1'b0;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mCursor = 3; mPlayer = 0; mInvalid = 0; mFull = 0;
        mRemain = -1; mTarget = 0; mFallLen = 0;
        for (int c = 0; c < 7; c++) mHeight[c] = 0;
    endtask

    task automatic modelStep(input bit l, input bit r, input bit p, input bit go);
        if (mRemain == 0) begin
            mHeight[mCursor] = mHeight[mCursor] + 1;
            mPlayer = 1 - mPlayer;
            mFull = 1;
            for (int c = 0; c < 7; c++) if (mHeight[c] != 6) mFull = 0;
            mRemain = -1;
        end else if (mRemain > 0) begin
            mRemain = mRemain - 1;
        end else if (p) begin
            if (!go) begin
                if (mHeight[mCursor] < 6) begin
                    mTarget = mHeight[mCursor];
                    mFallLen = ANIM ? DT * (6 - mTarget) : 0;
                    mRemain = mFallLen;
                    mInvalid = 0;
                end else begin
                    mInvalid = 1;
                end
            end
        end else if (l && !r) begin
            if (mCursor > 0) mCursor = mCursor - 1;
            mInvalid = 0;
        end else if (r && !l) begin
            if (mCursor < 6) mCursor = mCursor + 1;
            mInvalid = 0;
        end
    endtask

    task automatic checkOutput(input string name);
        logic [20:0] e, a;
        bit we, av;
        int row;
        we = (mRemain == 0);
        av = ANIM && (mRemain > 0);
        row = av ? 5 - (mFallLen - mRemain) / DT : 0;
        e = {3'(mCursor), 1'(mPlayer), 1'(mRemain >= 0), av, 3'(row), we,
             we ? 3'(mTarget) : 3'd0, we ? 3'(mCursor) : 3'd0,
             we ? (mPlayer != 0 ? 2'b10 : 2'b01) : 2'b00, we, 1'(mInvalid), 1'(mFull)};
        a = {cursor, player, busy, anim_valid, av ? anim_row : 3'd0, wr_en, wr_row, wr_col,
             wr_data, move_done, invalid_move, full_panel};
        checkVal($sformatf("%s@%0d", name, cycleNo), 32'(a), 32'(e));
    endtask

    task automatic applyStimulus(input bit l, input bit r, input bit p, input bit go);
        left = l; right = r; put = p; game_over = go;
        @(negedge clk);
        cycleNo++;
        modelStep(l, r, p, go);
        left = 1'b0; right = 1'b0; put = 1'b0;
        checkOutput("cycle");
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("reset");
        checkVal("resetAnimRow", 32'(anim_row), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitWrite(input string name, input int expLat, input bit poke);
        int cnt;
        cnt = 0;
        while (wr_en !== 1'b1 && cnt < 400) begin
            if (poke && mRemain > 0)
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                applyStimulus(1'b0, 1'b0, 1'b0, game_over);
            cnt++;
        end
        checkVal(name, cnt, expLat);
    endtask

    task automatic moveTo(input int col);
        for (int i = 0; i < 20 && mCursor != col; i++)
            applyStimulus(mCursor > col, mCursor < col, 1'b0, 1'b0);
    endtask

    task automatic dropAt(input int col, input bit poke);
        int lat;
        moveTo(col);
        lat = ANIM ? DT * (6 - mHeight[col]) : 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitWrite($sformatf("dropLatencyCol%0d", col), lat, poke);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #(1000000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2;
        doReset();

        // cursor saturation, simultaneous left/right and put priority
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 4));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 5));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 6));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 6));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 6));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 1'b0, 6));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 5));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 1'b1, 5));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 1'b1, 5));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 4));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 3));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 2));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 1'b0, 0));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].l, vecs[i].r, vecs[i].p, vecs[i].go);
            checkVal($sformatf("vec%0dCursor", i), 32'(cursor), vecs[i].cur);
            checkVal($sformatf("vec%0dBusy", i), 32'(busy), 32'(vecs[i].bsy));
            checkVal($sformatf("vec%0dInvalid", i), 32'(invalid_move), 32'(vecs[i].inv));
        end

        // first drop in the centre column
        moveTo(3);
        checkVal("drop1PlayerBefore", 32'(player), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("drop1Busy", 32'(busy), 1);
        checkVal("drop1AnimValid", 32'(anim_valid), 32'(ANIM));
        waitWrite("drop1Latency", ANIM ? 24 : 0, 1'b0);
        checkVal("drop1Row", 32'(wr_row), 0);
        checkVal("drop1Col", 32'(wr_col), 3);
        checkVal("drop1Data", 32'(wr_data), 1);
        checkVal("drop1MoveDone", 32'(move_done), 1);
        checkVal("drop1AnimOff", 32'(anim_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("drop1PlayerAfter", 32'(player), 1);
        checkVal("drop1Idle", 32'(busy), 0);

        // second drop stacks on the first; pulses during the fall are ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitWrite("drop2Latency", ANIM ? 20 : 0, 1'b1);
        checkVal("drop2Row", 32'(wr_row), 1);
        checkVal("drop2Data", 32'(wr_data), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("drop2Cursor", 32'(cursor), 3);
        checkVal("drop2Player", 32'(player), 0);

        // fill column 0, then an overflowing put
        for (int k = 0; k < 6; k++) dropAt(0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("fullColInvalid", 32'(invalid_move), 1);
        checkVal("fullColNoWrite", 32'(wr_en), 0);
        checkVal("fullColNotBusy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("invalidCleared", 32'(invalid_move), 0);
        checkVal("invalidClearCursor", 32'(cursor), 1);

        // game over blocks drops without flagging invalid moves
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkVal("gameOverNoBusy", 32'(busy), 0);
        moveTo(0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkVal("gameOverNoInvalid", 32'(invalid_move), 0);

        // reset in the middle of a drop abandons it
        moveTo(4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        doReset();
        checkVal("resetAbandonWr", 32'(wr_en), 0);
        for (int k = 0; k < 30; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        dropAt(4, 1'b0);

        // randomized pulses against the model
        doReset();
        for (int k = 0; k < 1500; k++)
            applyStimulus($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);

        // fill the whole panel
        doReset();
        for (int c = 0; c < 7; c++)
            for (int k = 0; k < 6; k++)
                if (!(c == 6 && k == 5)) dropAt(c, 1'b1);
        moveTo(6);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitWrite("lastDropLatency", ANIM ? DT : 0, 1'b0);
        checkVal("fullBeforeLast", 32'(full_panel), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("fullAfterLast", 32'(full_panel), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("fullPanelInvalid", 32'(invalid_move), 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
